// File: rtl/tl_sram_responder.sv
// tl_sram_responder: TileLink-UH manager terminating an A/D channel pair and
// backing a DEPTH x 64-bit register-array scratchpad located at BASE_ADDR.
// Serves Get/PutFull/PutPartial (bursts up to 64 B) and Hint; Arith/Logic and
// unknown opcodes, out-of-range addresses and oversize requests are denied.
// Build option: define TL_RESPONDER_READ_PIPE_EN to register the read data path
// (one extra cycle before the first D beat, back-to-back beats via prefetch).
`timescale 1ns/1ps
module tl_sram_responder #(
    parameter logic [30:0] BASE_ADDR = 31'h1000_0000,
    parameter int          DEPTH     = 512,
    parameter logic        SINK_ID   = 1'b0
) (
    input  logic        clock,
    input  logic        reset,
    output logic        auto_in_a_ready,
    input  logic        auto_in_a_valid,
    input  logic [2:0]  auto_in_a_bits_opcode,
    input  logic [2:0]  auto_in_a_bits_param,
    input  logic [3:0]  auto_in_a_bits_size,
    input  logic [2:0]  auto_in_a_bits_source,
    input  logic [30:0] auto_in_a_bits_address,
    input  logic [7:0]  auto_in_a_bits_mask,
    input  logic [63:0] auto_in_a_bits_data,
    input  logic        auto_in_a_bits_corrupt,
    input  logic        auto_in_d_ready,
    output logic        auto_in_d_valid,
    output logic [2:0]  auto_in_d_bits_opcode,
    output logic [1:0]  auto_in_d_bits_param,
    output logic [3:0]  auto_in_d_bits_size,
    output logic [2:0]  auto_in_d_bits_source,
    output logic        auto_in_d_bits_sink,
    output logic        auto_in_d_bits_denied,
    output logic [63:0] auto_in_d_bits_data,
    output logic        auto_in_d_bits_corrupt
);
    localparam int          IW       = $clog2(DEPTH);
    localparam logic [31:0] END_ADDR = {1'b0, BASE_ADDR} + 32'(DEPTH) * 32'd8;

    typedef enum logic [1:0] {IDLE, PUT, DATA, ACK} state_t;

    state_t         state, state_nx;
    logic [63:0]    mem [DEPTH];

    logic [2:0]     op_q;
    logic [3:0]     size_q;
    logic [2:0]     src_q;
    logic [IW-1:0]  base_q;
    logic           deny_q;
    logic [11:0]    cnt_q;
    logic [11:0]    last_q;

    logic           a_fire, d_fire, d_last;
    logic           in_range, deny_now, put_now, get_now, we;
    logic [30:0]    offset;
    logic [IW-1:0]  idx_now, wr_idx, rd_idx;
    logic [11:0]    last_now;
    logic [63:0]    rd_word;
    logic           rd_ok;
    logic           unused_ok;

    assign offset   = auto_in_a_bits_address - BASE_ADDR;
    assign idx_now  = offset[IW+2:3];
    assign in_range = ({1'b0, auto_in_a_bits_address} >= {1'b0, BASE_ADDR}) &&
                      ({1'b0, auto_in_a_bits_address} < END_ADDR);
    assign put_now  = (auto_in_a_bits_opcode[2:1] == 2'b00);
    assign get_now  = (auto_in_a_bits_opcode == 3'd4) || (auto_in_a_bits_opcode[2:1] == 2'b01);
    assign deny_now = !in_range || (auto_in_a_bits_size > 4'd6) || auto_in_a_bits_opcode[1];
    assign last_now = (auto_in_a_bits_size <= 4'd3) ? 12'd0
                    : (12'd1 << (auto_in_a_bits_size - 4'd3)) - 12'd1;
    assign unused_ok = ^{auto_in_a_bits_param, offset[30:IW+3], offset[2:0]};

    assign auto_in_a_ready     = reset && ((state == IDLE) || (state == PUT));
    assign a_fire              = auto_in_a_ready && auto_in_a_valid;
    assign d_fire              = auto_in_d_valid && auto_in_d_ready;
    assign d_last              = (cnt_q == last_q);
    assign auto_in_d_bits_param = 2'b00;
    assign auto_in_d_bits_sink  = SINK_ID;

    assign rd_idx = base_q + IW'(cnt_q);
    assign wr_idx = (state == IDLE) ? idx_now : base_q + IW'(cnt_q);
    assign we     = a_fire && !auto_in_a_bits_corrupt &&
                    ((state == IDLE) ? (put_now && !deny_now) : !deny_q);

    // State register; async reset abandons any transaction in flight
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    // Next-state decision from the request opcode and beat position
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (a_fire) begin
                if (put_now)      state_nx = (last_now == 12'd0) ? ACK : PUT;
                else if (get_now) state_nx = DATA;
                else              state_nx = ACK;
            end
            PUT:  if (a_fire && d_last) state_nx = ACK;
            DATA: if (d_fire && d_last) state_nx = IDLE;
            ACK:  if (d_fire)           state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Request context latched on the first beat plus the shared beat counter
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            op_q   <= '0;
            size_q <= '0;
            src_q  <= '0;
            base_q <= '0;
            deny_q <= 1'b0;
            cnt_q  <= '0;
            last_q <= '0;
        end else begin
            case (state)
                IDLE: if (a_fire) begin
                    op_q   <= auto_in_a_bits_opcode;
                    size_q <= auto_in_a_bits_size;
                    src_q  <= auto_in_a_bits_source;
                    base_q <= idx_now;
                    deny_q <= deny_now;
                    last_q <= last_now;
                    cnt_q  <= (put_now && last_now != 12'd0) ? 12'd1 : 12'd0;
                end
                PUT:  if (a_fire) cnt_q <= d_last ? 12'd0 : cnt_q + 12'd1;
                DATA: if (d_fire) cnt_q <= d_last ? 12'd0 : cnt_q + 12'd1;
                default: ;
            endcase
        end
    end

    // Scratchpad byte-lane write port; the array is deliberately never cleared
    always_ff @(posedge clock) begin
        if (we) begin
            for (int b = 0; b < 8; b++) begin
                if (auto_in_a_bits_mask[b]) mem[wr_idx][8*b +: 8] <= auto_in_a_bits_data[8*b +: 8];
            end
        end
    end

`ifdef TL_RESPONDER_READ_PIPE_EN
    logic [63:0] rd_q;
    logic        rd_ok_q;

    // Registered read: first fetch on DATA entry, then prefetch the next beat on each fire
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_q    <= '0;
            rd_ok_q <= 1'b0;
        end else if (state != DATA) begin
            rd_ok_q <= 1'b0;
        end else if (!rd_ok_q) begin
            rd_q    <= mem[rd_idx];
            rd_ok_q <= 1'b1;
        end else if (d_fire && !d_last) begin
            rd_q    <= mem[rd_idx + IW'(1)];
        end
    end

    assign rd_word = rd_q;
    assign rd_ok   = rd_ok_q;
`else
    assign rd_word = mem[rd_idx];
    assign rd_ok   = 1'b1;
`endif

    // D channel drive; all response fields read as zero whenever no beat is offered
    always_comb begin
        auto_in_d_valid        = 1'b0;
        auto_in_d_bits_opcode  = 3'd0;
        auto_in_d_bits_size    = 4'd0;
        auto_in_d_bits_source  = 3'd0;
        auto_in_d_bits_denied  = 1'b0;
        auto_in_d_bits_data    = 64'd0;
        auto_in_d_bits_corrupt = 1'b0;
        if (state == ACK) begin
            auto_in_d_valid       = 1'b1;
            auto_in_d_bits_opcode = (op_q == 3'd5) ? 3'd2 : 3'd0;
            auto_in_d_bits_size   = size_q;
            auto_in_d_bits_source = src_q;
            auto_in_d_bits_denied = deny_q;
        end else if (state == DATA && rd_ok) begin
            auto_in_d_valid        = 1'b1;
            auto_in_d_bits_opcode  = 3'd1;
            auto_in_d_bits_size    = size_q;
            auto_in_d_bits_source  = src_q;
            auto_in_d_bits_denied  = deny_q;
            auto_in_d_bits_corrupt = deny_q;
            auto_in_d_bits_data    = deny_q ? 64'd0 : rd_word;
        end
    end
endmodule
